// File: rtl/elevator_ctrl_if.sv
// rtl/elevator_ctrl_if.sv - request/clear handshake between buttons_res and elevator_ctrl
//
// Purpose: bundles the latched request vectors and their clear strobes.
// Ports (signals):
//   active_in_levels          cabin requests, bit i = level i
//   active_out_up_levels      hall-up requests, levels 0..BUTTONS_WIDTH-2
//   active_out_down_levels    hall-down requests, levels 1..BUTTONS_WIDTH-1
//   inactivate_in_levels      clears for cabin requests
//   inactivate_out_up_levels  clears for hall-up requests
//   inactivate_out_down_levels clears for hall-down requests
// Modports: master = request holder (buttons_res), slave = elevator_ctrl.
interface elevator_ctrl_if #(
    parameter int BUTTONS_WIDTH = 8
);
    logic [BUTTONS_WIDTH-1:0] active_in_levels;
    logic [BUTTONS_WIDTH-2:0] active_out_up_levels;
    logic [BUTTONS_WIDTH-1:1] active_out_down_levels;
    logic [BUTTONS_WIDTH-1:0] inactivate_in_levels;
    logic [BUTTONS_WIDTH-2:0] inactivate_out_up_levels;
    logic [BUTTONS_WIDTH-1:1] inactivate_out_down_levels;

    modport master (
        output active_in_levels,
        output active_out_up_levels,
        output active_out_down_levels,
        input  inactivate_in_levels,
        input  inactivate_out_up_levels,
        input  inactivate_out_down_levels
    );

    modport slave (
        input  active_in_levels,
        input  active_out_up_levels,
        input  active_out_down_levels,
        output inactivate_in_levels,
        output inactivate_out_up_levels,
        output inactivate_out_down_levels
    );
endinterface

// File: rtl/elevator_ctrl.sv
// rtl/elevator_ctrl.sv - SCAN-style car-motion controller servicing latched requests
//
// Purpose: tracks the car level, schedules up/down travel with a per-level
// travel time, dwells with the door open and clears the serviced requests.
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   req            elevator_ctrl_if.slave: active_* in, inactivate_* out
//   current_level  registered car level
//   dir_up         scheduling direction, 1 = up
//   moving         high in MOVE_UP / MOVE_DOWN / ARRIVE
//   door_open      high in DOOR_OPEN
module elevator_ctrl #(
    parameter int BUTTONS_WIDTH = 8,
    parameter int LEVEL_WIDTH   = 3,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    elevator_ctrl_if.slave         req,
    output logic [LEVEL_WIDTH-1:0] current_level,
    output logic                   dir_up,
    output logic                   moving,
    output logic                   door_open
);
    localparam int MAX_CYCLES  = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TIMER_WIDTH = $clog2(MAX_CYCLES + 1);
    localparam logic [TIMER_WIDTH-1:0] TRAVEL_LAST = TIMER_WIDTH'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] DOOR_LAST   = TIMER_WIDTH'(DOOR_CYCLES - 1);
    localparam logic [LEVEL_WIDTH-1:0] TOP_LEVEL   = LEVEL_WIDTH'(BUTTONS_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        ARRIVE,
        DOOR_OPEN
    } state_t;

    state_t                   state;
    logic [TIMER_WIDTH-1:0]   timer;
    logic [BUTTONS_WIDTH-1:0] clr_in;
    logic [BUTTONS_WIDTH-2:0] clr_up;
    logic [BUTTONS_WIDTH-1:1] clr_down;

    // Hall vectors widened to full level range; nonexistent bits read as 0.
    logic [BUTTONS_WIDTH-1:0] up_full;
    logic [BUTTONS_WIDTH-1:0] down_full;
    logic [BUTTONS_WIDTH-1:0] all_req;
    logic [BUTTONS_WIDTH-1:0] level_onehot;
    logic                     in_at;
    logic                     up_at;
    logic                     down_at;
    logic                     req_at;
    logic                     req_above;
    logic                     req_below;
    logic                     beyond;
    logic                     stop_here;
    logic [BUTTONS_WIDTH-1:0] door_clr_in;
    logic [BUTTONS_WIDTH-2:0] door_clr_up;
    logic [BUTTONS_WIDTH-1:1] door_clr_down;

    always_comb begin
        up_full      = {1'b0, req.active_out_up_levels};
        down_full    = {req.active_out_down_levels, 1'b0};
        all_req      = req.active_in_levels | up_full | down_full;
        level_onehot = BUTTONS_WIDTH'(1) << current_level;
        in_at        = |(req.active_in_levels & level_onehot);
        up_at        = |(up_full & level_onehot);
        down_at      = |(down_full & level_onehot);
        req_at       = in_at | up_at | down_at;
        req_above    = 1'b0;
        req_below    = 1'b0;
        for (int i = 0; i < BUTTONS_WIDTH; i++) begin
            if (LEVEL_WIDTH'(i) > current_level) req_above = req_above | all_req[i];
            if (LEVEL_WIDTH'(i) < current_level) req_below = req_below | all_req[i];
        end
        // Requests still waiting further along the current direction.
        beyond    = dir_up ? req_above : req_below;
        // Stop for a cabin call, a hall call heading our way, or the last
        // call in this direction regardless of its hall direction.
        stop_here = in_at | (dir_up ? up_at : down_at) | (req_at & ~beyond);
        // Clears latched on DOOR_OPEN entry. With nothing beyond, the car
        // turns around here, so both hall calls at this level are served.
        door_clr_in   = level_onehot;
        door_clr_up   = (~beyond | dir_up)  ? level_onehot[BUTTONS_WIDTH-2:0] : '0;
        door_clr_down = (~beyond | ~dir_up) ? level_onehot[BUTTONS_WIDTH-1:1] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            current_level <= '0;
            dir_up        <= 1'b1;
            timer         <= '0;
            moving        <= 1'b0;
            door_open     <= 1'b0;
            clr_in        <= '0;
            clr_up        <= '0;
            clr_down      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_at) begin
                        state     <= DOOR_OPEN;
                        door_open <= 1'b1;
                        timer     <= '0;
                        clr_in    <= door_clr_in;
                        clr_up    <= door_clr_up;
                        clr_down  <= door_clr_down;
                        if (!beyond) dir_up <= ~dir_up;
                    end else if (dir_up && req_above) begin
                        state  <= MOVE_UP;
                        moving <= 1'b1;
                        timer  <= '0;
                    end else if (req_below) begin
                        state  <= MOVE_DOWN;
                        dir_up <= 1'b0;
                        moving <= 1'b1;
                        timer  <= '0;
                    end else if (req_above) begin
                        state  <= MOVE_UP;
                        dir_up <= 1'b1;
                        moving <= 1'b1;
                        timer  <= '0;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (timer == TRAVEL_LAST) begin
                        timer <= '0;
                        state <= ARRIVE;
                        if (state == MOVE_UP) begin
                            if (current_level != TOP_LEVEL) current_level <= current_level + 1'b1;
                        end else begin
                            if (current_level != '0) current_level <= current_level - 1'b1;
                        end
                    end else begin
                        timer <= timer + TIMER_WIDTH'(1);
                    end
                end
                ARRIVE: begin
                    if (stop_here) begin
                        state     <= DOOR_OPEN;
                        moving    <= 1'b0;
                        door_open <= 1'b1;
                        timer     <= '0;
                        clr_in    <= door_clr_in;
                        clr_up    <= door_clr_up;
                        clr_down  <= door_clr_down;
                        if (!beyond) dir_up <= ~dir_up;
                    end else if (beyond) begin
                        // dir_up always matches the travel direction while moving.
                        state <= dir_up ? MOVE_UP : MOVE_DOWN;
                        timer <= '0;
                    end else begin
                        // Request withdrawn mid-travel: nothing left to serve.
                        state  <= IDLE;
                        moving <= 1'b0;
                    end
                end
                DOOR_OPEN: begin
                    if (timer == DOOR_LAST) begin
                        state     <= IDLE;
                        door_open <= 1'b0;
                        timer     <= '0;
                        clr_in    <= '0;
                        clr_up    <= '0;
                        clr_down  <= '0;
                    end else begin
                        timer <= timer + TIMER_WIDTH'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    moving    <= 1'b0;
                    door_open <= 1'b0;
                    timer     <= '0;
                    clr_in    <= '0;
                    clr_up    <= '0;
                    clr_down  <= '0;
                end
            endcase
        end
    end

    assign req.inactivate_in_levels       = clr_in;
    assign req.inactivate_out_up_levels   = clr_up;
    assign req.inactivate_out_down_levels = clr_down;
endmodule

// File: tb/tb_elevator_ctrl.sv
// tb/tb_elevator_ctrl.sv - directed self-checking bench for elevator_ctrl
module tb_elevator_ctrl;
    logic       clk;
    logic       reset;
    logic [2:0] current_level;
    logic       dir_up;
    logic       moving;
    logic       door_open;

    logic [7:0] press_in;
    logic [6:0] press_up;
    logic [7:1] press_down;
    logic [7:0] lat_in;
    logic [6:0] lat_up;
    logic [7:1] lat_down;

    int n_cmp;
    int n_bad;

    elevator_ctrl_if #(.BUTTONS_WIDTH(8)) bus ();

    elevator_ctrl #(
        .BUTTONS_WIDTH(8),
        .LEVEL_WIDTH(3),
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(bus.slave),
        .current_level(current_level),
        .dir_up(dir_up),
        .moving(moving),
        .door_open(door_open)
    );

    // Stand-in for buttons_res: presses latch, clears win over presses.
    always @(posedge clk) begin
        if (reset) begin
            lat_in   <= '0;
            lat_up   <= '0;
            lat_down <= '0;
        end else begin
            lat_in   <= (lat_in | press_in) & ~bus.inactivate_in_levels;
            lat_up   <= (lat_up | press_up) & ~bus.inactivate_out_up_levels;
            lat_down <= (lat_down | press_down) & ~bus.inactivate_out_down_levels;
        end
    end

    assign bus.active_in_levels       = lat_in;
    assign bus.active_out_up_levels   = lat_up;
    assign bus.active_out_down_levels = lat_down;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset      = 1'b1;
        press_in   = '0;
        press_up   = '0;
        press_down = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_door(input int max, output bit ok);
        ok = door_open;
        for (int i = 0; i < max && !ok; i++) begin
            step();
            if (door_open) ok = 1'b1;
        end
    endtask

    task automatic wait_close(input int max);
        for (int i = 0; i < max && door_open; i++) step();
    endtask

    task automatic test_reset;
        do_reset();
        n_cmp++;
        if (current_level !== 3'd0) begin n_bad++; $display("FAIL reset_level got %0d want 0", current_level); end
        n_cmp++;
        if (dir_up !== 1'b1) begin n_bad++; $display("FAIL reset_dir got %b want 1", dir_up); end
        n_cmp++;
        if ({moving, door_open} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b want 00", {moving, door_open}); end
        n_cmp++;
        if ({bus.inactivate_in_levels, bus.inactivate_out_up_levels, bus.inactivate_out_down_levels} !== 22'd0) begin
            n_bad++; $display("FAIL reset_inact got %h want 0",
                {bus.inactivate_in_levels, bus.inactivate_out_up_levels, bus.inactivate_out_down_levels});
        end
    endtask

    task automatic test_travel_up;
        int cnt;
        bit hold_ok;
        do_reset();
        press_in = 8'h08;
        step();
        press_in = '0;
        n_cmp++;
        if (moving !== 1'b0) begin n_bad++; $display("FAIL up_idle_first got %b want 0", moving); end
        step();
        n_cmp++;
        if ({moving, current_level} !== {1'b1, 3'd0}) begin n_bad++; $display("FAIL up_start got %b/%0d want 1/0", moving, current_level); end
        repeat (4) step();
        n_cmp++;
        if (current_level !== 3'd1) begin n_bad++; $display("FAIL up_level1 got %0d want 1", current_level); end
        repeat (5) step();
        n_cmp++;
        if (current_level !== 3'd2) begin n_bad++; $display("FAIL up_level2 got %0d want 2", current_level); end
        repeat (5) step();
        n_cmp++;
        if ({current_level, moving, door_open} !== {3'd3, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL up_level3 got %0d/%b/%b want 3/1/0", current_level, moving, door_open);
        end
        step();
        n_cmp++;
        if ({door_open, moving} !== 2'b10) begin n_bad++; $display("FAIL up_door_open got %b want 10", {door_open, moving}); end
        cnt = 0;
        hold_ok = 1'b1;
        for (int i = 0; i < 10 && door_open; i++) begin
            cnt++;
            if (bus.inactivate_in_levels !== 8'h08) hold_ok = 1'b0;
            step();
        end
        n_cmp++;
        if (cnt !== 3) begin n_bad++; $display("FAIL up_door_cycles got %0d want 3", cnt); end
        n_cmp++;
        if (hold_ok !== 1'b1) begin n_bad++; $display("FAIL up_clear_held got %b want 1", hold_ok); end
        n_cmp++;
        if ({dir_up, moving, bus.inactivate_in_levels} !== {1'b0, 1'b0, 8'h00}) begin
            n_bad++; $display("FAIL up_after got %b/%b/%h want 0/0/00", dir_up, moving, bus.inactivate_in_levels);
        end
    endtask

    task automatic test_hall_at_level;
        int cnt;
        bit still;
        do_reset();
        press_up = 7'b0000001;
        step();
        press_up = '0;
        n_cmp++;
        if (door_open !== 1'b0) begin n_bad++; $display("FAIL here_pre got %b want 0", door_open); end
        step();
        n_cmp++;
        if ({door_open, moving, bus.inactivate_out_up_levels} !== {1'b1, 1'b0, 7'b0000001}) begin
            n_bad++; $display("FAIL here_open got %b/%b/%b want 1/0/0000001", door_open, moving, bus.inactivate_out_up_levels);
        end
        cnt = 0;
        still = 1'b1;
        for (int i = 0; i < 10 && door_open; i++) begin
            cnt++;
            if (moving !== 1'b0 || bus.inactivate_out_up_levels !== 7'b0000001) still = 1'b0;
            step();
        end
        n_cmp++;
        if ({cnt == 3, still} !== 2'b11) begin n_bad++; $display("FAIL here_dwell got cnt=%0d ok=%b want cnt=3 ok=1", cnt, still); end
        n_cmp++;
        if (moving !== 1'b0) begin n_bad++; $display("FAIL here_no_move got %b want 0", moving); end
    endtask

    task automatic test_scan;
        bit ok;
        do_reset();
        press_in = 8'h20;
        step();
        press_in = '0;
        step();
        press_up   = 7'b0000100;
        press_down = 7'b0000100;
        step();
        press_up   = '0;
        press_down = '0;
        wait_door(60, ok);
        n_cmp++;
        if ({ok, current_level, dir_up} !== {1'b1, 3'd2, 1'b1}) begin
            n_bad++; $display("FAIL scan_stop2 got ok=%b lvl=%0d dir=%b want 1/2/1", ok, current_level, dir_up);
        end
        n_cmp++;
        if ({bus.inactivate_in_levels, bus.inactivate_out_up_levels, bus.inactivate_out_down_levels}
            !== {8'h04, 7'b0000100, 7'b0000000}) begin
            n_bad++; $display("FAIL scan_clear2 got %h/%b/%b want 04/0000100/0000000",
                bus.inactivate_in_levels, bus.inactivate_out_up_levels, bus.inactivate_out_down_levels);
        end
        wait_close(10);
        wait_door(60, ok);
        n_cmp++;
        if ({ok, current_level, dir_up} !== {1'b1, 3'd5, 1'b0}) begin
            n_bad++; $display("FAIL scan_stop5 got ok=%b lvl=%0d dir=%b want 1/5/0", ok, current_level, dir_up);
        end
        n_cmp++;
        if ({bus.inactivate_in_levels, bus.inactivate_out_up_levels, bus.inactivate_out_down_levels}
            !== {8'h20, 7'b0100000, 7'b0010000}) begin
            n_bad++; $display("FAIL scan_clear5 got %h/%b/%b want 20/0100000/0010000",
                bus.inactivate_in_levels, bus.inactivate_out_up_levels, bus.inactivate_out_down_levels);
        end
        wait_close(10);
        wait_door(60, ok);
        n_cmp++;
        if ({ok, current_level, dir_up} !== {1'b1, 3'd3, 1'b1}) begin
            n_bad++; $display("FAIL scan_stop3 got ok=%b lvl=%0d dir=%b want 1/3/1", ok, current_level, dir_up);
        end
        n_cmp++;
        if ({bus.inactivate_in_levels, bus.inactivate_out_up_levels, bus.inactivate_out_down_levels}
            !== {8'h08, 7'b0001000, 7'b0000100}) begin
            n_bad++; $display("FAIL scan_clear3 got %h/%b/%b want 08/0001000/0000100",
                bus.inactivate_in_levels, bus.inactivate_out_up_levels, bus.inactivate_out_down_levels);
        end
        wait_close(10);
    endtask

    task automatic test_top_hall_down;
        bit ok;
        do_reset();
        press_down = 7'b1000000;
        step();
        press_down = '0;
        wait_door(80, ok);
        n_cmp++;
        if ({ok, current_level} !== {1'b1, 3'd7}) begin n_bad++; $display("FAIL top_stop got ok=%b lvl=%0d want 1/7", ok, current_level); end
        n_cmp++;
        if ({bus.inactivate_in_levels, bus.inactivate_out_up_levels, bus.inactivate_out_down_levels}
            !== {8'h80, 7'b0000000, 7'b1000000}) begin
            n_bad++; $display("FAIL top_clear got %h/%b/%b want 80/0000000/1000000",
                bus.inactivate_in_levels, bus.inactivate_out_up_levels, bus.inactivate_out_down_levels);
        end
        wait_close(10);
        n_cmp++;
        if ({dir_up, door_open} !== 2'b00) begin n_bad++; $display("FAIL top_dir got %b want 00", {dir_up, door_open}); end
    endtask

    task automatic test_reset_mid_move;
        do_reset();
        press_in = 8'h80;
        step();
        press_in = '0;
        for (int i = 0; i < 80 && current_level != 3'd4; i++) step();
        step();
        n_cmp++;
        if ({current_level, moving} !== {3'd4, 1'b1}) begin
            n_bad++; $display("FAIL mid_move_pre got %0d/%b want 4/1", current_level, moving);
        end
        reset = 1'b1;
        step();
        n_cmp++;
        if ({current_level, dir_up, moving, door_open} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL mid_move_reset got %0d/%b/%b/%b want 0/1/0/0", current_level, dir_up, moving, door_open);
        end
        n_cmp++;
        if ({bus.inactivate_in_levels, bus.inactivate_out_up_levels, bus.inactivate_out_down_levels} !== 22'd0) begin
            n_bad++; $display("FAIL mid_move_inact got %h want 0",
                {bus.inactivate_in_levels, bus.inactivate_out_up_levels, bus.inactivate_out_down_levels});
        end
        reset = 1'b0;
    endtask

    task automatic test_quiet;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            step();
            n_cmp++;
            if ({current_level, dir_up, moving, door_open, bus.inactivate_in_levels,
                 bus.inactivate_out_up_levels, bus.inactivate_out_down_levels} !== {3'd0, 1'b1, 24'd0}) begin
                n_bad++; $display("FAIL quiet_cycle%0d got %0d/%b/%b/%b want 0/1/0/0", i, current_level, dir_up, moving, door_open);
            end
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b1;
        press_in   = '0;
        press_up   = '0;
        press_down = '0;
        @(negedge clk);
        test_reset();
        test_travel_up();
        test_hall_at_level();
        test_scan();
        test_top_hall_down();
        test_reset_mid_move();
        test_quiet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
